vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator: h/v position counters, sync pulses of configurable polarity,
//  a data-enable, line/frame strobes and blanked RGB output of configurable depth. Sits between the

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_pos_delay.sv | 50 +++++
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and sync polarity constants.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam logic POL_LOW  = 1'b0;
   localparam logic POL_HIGH = 1'b1;

   function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_pos_delay.sv
// Enable-gated h/v position shift pipeline; depth 0 is a pure pass-through.
module vga_pos_delay #(
   parameter int unsigned W     = 11,
   parameter int unsigned DEPTH = 0
) (
   input  logic         clk,
   input  logic         rst_p,
   input  logic         en,
   input  logic [W-1:0] h_in,
   input  logic [W-1:0] v_in,
   output logic [W-1:0] h_out,
   output logic [W-1:0] v_out
);

   if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst_p, en};
      assign h_out = h_in;
      assign v_out = v_in;
   end else begin : g_pipe
      localparam int unsigned PW = DEPTH * W;

      logic [PW-1:0] h_q, h_d;
      logic [PW-1:0] v_q, v_d;

      // Newest stage sits in the low W bits; the oldest drives the outputs.
      always_comb begin
         h_d = h_q;
         v_d = v_q;
         if (en) begin
            h_d = PW'({h_q, h_in});
            v_d = PW'({v_q, v_in});
         end
      end

      always_ff @(posedge clk or posedge rst_p) begin
         if (rst_p) begin
            h_q <= '0;
            v_q <= '0;
         end else begin
            h_q <= h_d;
            v_q <= v_d;
         end
      end

      assign h_out = h_q[PW-1 -: W];
      assign v_out = v_q[PW-1 -: W];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: position counters, genlock restart, frame counter, strobes and a
// registered sync/data-enable/RGB stage fed from a delayed copy of the position.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned COLOR_W    = 4,
   parameter int unsigned CNT_W      = 11,
   parameter int unsigned PIPE_DELAY = 0,
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter logic        HS_POL     = POL_LOW,
   parameter logic        VS_POL     = POL_LOW,
   parameter int unsigned FRAME_W    = 8
) (
   input  logic               clk,
   input  logic               rst_p,
   input  logic               clk_en,
   input  logic               restart,
   input  logic [COLOR_W-1:0] r,
   input  logic [COLOR_W-1:0] g,
   input  logic [COLOR_W-1:0] b,
   output logic [CNT_W-1:0]   h_pos,
   output logic [CNT_W-1:0]   v_pos,
   output logic               v_blank,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               de,
   output logic               h_sync,
   output logic               v_sync,
   output logic [COLOR_W-1:0] red_out,
   output logic [COLOR_W-1:0] green_out,
   output logic [COLOR_W-1:0] blue_out
);

   localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if ((((H_TOTAL - 1) >> CNT_W) != 0) || (((V_TOTAL - 1) >> CNT_W) != 0)) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
             CNT_W, H_TOTAL - 1, V_TOTAL - 1);
   end
   if (PIPE_DELAY > 15) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE_DELAY=%0d out of range 0..15", PIPE_DELAY);
   end

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic               de_q, de_d;
   logic               h_sync_q, h_sync_d;
   logic               v_sync_q, v_sync_d;
   logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

   logic [CNT_W-1:0]   h_dly, v_dly;
   logic               active;

   vga_pos_delay #(
      .W     (CNT_W),
      .DEPTH (PIPE_DELAY)
   ) u_pos_delay (
      .clk   (clk),
      .rst_p (rst_p),
      .en    (clk_en),
      .h_in  (h_q),
      .v_in  (v_q),
      .h_out (h_dly),
      .v_out (v_dly)
   );

   // Counter advance, genlock override, strobes and the pin-side output stage.
   always_comb begin
      h_d           = h_q;
      v_d           = v_q;
      frame_d       = frame_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      de_d          = de_q;
      h_sync_d      = h_sync_q;
      v_sync_d      = v_sync_q;
      red_d         = red_q;
      green_d       = green_q;
      blue_d        = blue_q;
      active        = (h_dly < H_ACT) && (v_dly < V_ACT);

      if (clk_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d     = '0;
               frame_d = frame_q + FRAME_W'(1);
            end else begin
               v_d = v_q + CNT_W'(1);
            end
         end else begin
            h_d = h_q + CNT_W'(1);
         end

         // Restart wins over the natural wrap but keeps a coincident frame count.
         if (restart) begin
            h_d = '0;
            v_d = '0;
         end

         line_start_d  = (h_d == '0);
         frame_start_d = (h_d == '0) && (v_d == '0);

         de_d     = active;
         red_d    = active ? r : '0;
         green_d  = active ? g : '0;
         blue_d   = active ? b : '0;
         h_sync_d = ((h_dly >= HS_BEG) && (h_dly < HS_END)) ? HS_POL : ~HS_POL;
         v_sync_d = ((v_dly >= VS_BEG) && (v_dly < VS_END)) ? VS_POL : ~VS_POL;
      end
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         h_q           <= '0;
         v_q           <= '0;
         frame_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         de_q          <= 1'b0;
         h_sync_q      <= ~HS_POL;
         v_sync_q      <= ~VS_POL;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         frame_q       <= frame_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         de_q          <= de_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
      end
   end

   assign h_pos       = h_q;
   assign v_pos       = v_q;
   assign v_blank     = (v_q >= V_ACT);
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_q;
   assign de          = de_q;
   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign red_out     = red_q;
   assign green_out   = green_q;
   assign blue_out    = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance plus a tiny 24x10 instance with PIPE_DELAY=3
// and active-high syncs, sharing clock, reset, enable and restart.
module tb_vga_timing_gen;

   logic clk, rst_p, clk_en, restart;
   int   k;
   int   n_pass, n_total;

   // default instance (suffix _a)
   logic [3:0]  r_a, g_a, b_a;
   logic [10:0] h_a, v_a;
   logic        vb_a, ls_a, fs_a, de_a, hs_a, vs_a;
   logic [7:0]  fc_a;
   logic [3:0]  red_a, grn_a, blu_a;

   // small instance (suffix _s): H 16+2+3+3=24, V 6+1+2+1=10
   logic [3:0]  r_s, g_s, b_s;
   logic [10:0] h_s, v_s;
   logic        vb_s, ls_s, fs_s, de_s, hs_s, vs_s;
   logic [7:0]  fc_s;
   logic [3:0]  red_s, grn_s, blu_s;
   logic [2:0][3:0] rdly;

   vga_timing_gen u_dut_a (
      .clk(clk), .rst_p(rst_p), .clk_en(clk_en), .restart(restart),
      .r(r_a), .g(g_a), .b(b_a),
      .h_pos(h_a), .v_pos(v_a), .v_blank(vb_a), .line_start(ls_a), .frame_start(fs_a),
      .frame_cnt(fc_a), .de(de_a), .h_sync(hs_a), .v_sync(vs_a),
      .red_out(red_a), .green_out(grn_a), .blue_out(blu_a)
   );

   vga_timing_gen #(
      .PIPE_DELAY(3),
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_dut_s (
      .clk(clk), .rst_p(rst_p), .clk_en(clk_en), .restart(restart),
      .r(r_s), .g(g_s), .b(b_s),
      .h_pos(h_s), .v_pos(v_s), .v_blank(vb_s), .line_start(ls_s), .frame_start(fs_s),
      .frame_cnt(fc_s), .de(de_s), .h_sync(hs_s), .v_sync(vs_s),
      .red_out(red_s), .green_out(grn_s), .blue_out(blu_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign r_a = h_a[3:0];
   assign g_a = 4'hA;
   assign b_a = 4'h5;

   // Pixel source with three enabled steps of latency for the delayed instance.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) rdly <= '0;
      else if (clk_en) rdly <= {rdly[1:0], h_s[3:0]};
   end
   assign r_s = rdly[2];
   assign g_s = 4'h3;
   assign b_s = 4'hC;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
   endtask

   task automatic adv_to(input int target);
      while (k < target) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0; k = 0;
      rst_p = 1'b1; clk_en = 1'b0; restart = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_h_a", 32'(h_a), 0);      chk("rst_v_a", 32'(v_a), 0);
      chk("rst_hs_a", 32'(hs_a), 1);    chk("rst_vs_a", 32'(vs_a), 1);
      chk("rst_de_a", 32'(de_a), 0);    chk("rst_fc_a", 32'(fc_a), 0);
      chk("rst_red_a", 32'(red_a), 0);  chk("rst_ls_a", 32'(ls_a), 0);
      chk("rst_fs_a", 32'(fs_a), 0);
      chk("rst_hs_s", 32'(hs_s), 0);    chk("rst_vs_s", 32'(vs_s), 0);
      chk("rst_de_s", 32'(de_s), 0);

      rst_p = 1'b0; clk_en = 1'b1;
      adv_to(1);
      chk("h_a_1", 32'(h_a), 1);  chk("vb_a_1", 32'(vb_a), 0);  chk("ls_a_1", 32'(ls_a), 0);

      // small instance: pin shows position from 4 steps earlier
      adv_to(19);
      chk("red_s_15", 32'(red_s), 15); chk("de_s_on", 32'(de_s), 1);
      chk("grn_s_on", 32'(grn_s), 3);  chk("blu_s_on", 32'(blu_s), 12);
      adv_to(20);
      chk("de_s_off", 32'(de_s), 0);   chk("red_s_off", 32'(red_s), 0);
      adv_to(21); chk("hs_s_pre", 32'(hs_s), 0);
      adv_to(22); chk("hs_s_beg", 32'(hs_s), 1);
      adv_to(24);
      chk("hs_s_last", 32'(hs_s), 1); chk("ls_s_24", 32'(ls_s), 1);
      chk("fs_s_24", 32'(fs_s), 0);   chk("h_s_24", 32'(h_s), 0);  chk("v_s_24", 32'(v_s), 1);
      adv_to(25);
      chk("hs_s_end", 32'(hs_s), 0);  chk("ls_s_25", 32'(ls_s), 0);
      adv_to(143); chk("vb_s_143", 32'(vb_s), 0);
      adv_to(144); chk("vb_s_144", 32'(vb_s), 1);
      adv_to(171); chk("vs_s_pre", 32'(vs_s), 0);
      adv_to(172); chk("vs_s_beg", 32'(vs_s), 1);
      adv_to(219); chk("vs_s_last", 32'(vs_s), 1);
      adv_to(220); chk("vs_s_end", 32'(vs_s), 0);
      adv_to(239); chk("fc_s_239", 32'(fc_s), 0); chk("fs_s_239", 32'(fs_s), 0);
      adv_to(240);
      chk("fc_s_240", 32'(fc_s), 1); chk("fs_s_240", 32'(fs_s), 1);
      chk("h_s_240", 32'(h_s), 0);   chk("v_s_240", 32'(v_s), 0);  chk("vb_s_240", 32'(vb_s), 0);
      adv_to(241); chk("fs_s_241", 32'(fs_s), 0);
      adv_to(480); chk("fc_s_480", 32'(fc_s), 2);

      // default instance, line 0 edges (one step of output latency)
      adv_to(640);
      chk("de_a_639", 32'(de_a), 1);   chk("red_a_639", 32'(red_a), 15);
      chk("grn_a_639", 32'(grn_a), 10); chk("blu_a_639", 32'(blu_a), 5);
      adv_to(641); chk("de_a_640", 32'(de_a), 0); chk("red_a_640", 32'(red_a), 0);
      adv_to(656); chk("hs_a_655", 32'(hs_a), 1);
      adv_to(657); chk("hs_a_656", 32'(hs_a), 0);
      adv_to(752); chk("hs_a_751", 32'(hs_a), 0);
      adv_to(753); chk("hs_a_752", 32'(hs_a), 1);
      adv_to(800);
      chk("ls_a_800", 32'(ls_a), 1); chk("fs_a_800", 32'(fs_a), 0);
      chk("h_a_800", 32'(h_a), 0);   chk("v_a_800", 32'(v_a), 1);  chk("vs_a_800", 32'(vs_a), 1);
      adv_to(801); chk("ls_a_801", 32'(ls_a), 0);

      // clk_en 1-in-2
      repeat (14) begin
         clk_en = 1'b1; @(negedge clk);
         clk_en = 1'b0; @(negedge clk);
      end
      k = 815;
      chk("h_s_815_hold", 32'(h_s), 23);
      clk_en = 1'b1; @(negedge clk); k = 816;
      chk("ls_s_816", 32'(ls_s), 1); chk("h_s_816", 32'(h_s), 0); chk("v_s_816", 32'(v_s), 4);
      chk("h_a_816", 32'(h_a), 16);  chk("red_a_816", 32'(red_a), 15);
      clk_en = 1'b0; @(negedge clk);
      chk("ls_s_gap", 32'(ls_s), 0); chk("h_s_gap", 32'(h_s), 0);
      chk("h_a_gap", 32'(h_a), 16);  chk("red_a_gap", 32'(red_a), 15); chk("de_a_gap", 32'(de_a), 1);
      clk_en = 1'b1; @(negedge clk);
      clk_en = 1'b0; @(negedge clk); k = 817;
      chk("h_a_817", 32'(h_a), 17);
      clk_en = 1'b1;

      // restart mid-frame (small at h=10,v=5; default at h=50,v=1)
      adv_to(850);
      restart = 1'b1; @(negedge clk); restart = 1'b0; k = 0;
      chk("rs_h_s", 32'(h_s), 0);  chk("rs_v_s", 32'(v_s), 0);
      chk("rs_ls_s", 32'(ls_s), 1); chk("rs_fs_s", 32'(fs_s), 1); chk("rs_fc_s", 32'(fc_s), 3);
      chk("rs_h_a", 32'(h_a), 0);  chk("rs_v_a", 32'(v_a), 0);
      chk("rs_fs_a", 32'(fs_a), 1); chk("rs_fc_a", 32'(fc_a), 0);
      adv_to(1);
      chk("rs1_h_s", 32'(h_s), 1); chk("rs1_fs_s", 32'(fs_s), 0); chk("rs1_fc_s", 32'(fc_s), 3);

      // restart coinciding with the natural frame wrap
      adv_to(239);
      chk("wr_h_s", 32'(h_s), 23); chk("wr_v_s", 32'(v_s), 9); chk("wr_fc_s", 32'(fc_s), 3);
      restart = 1'b1; @(negedge clk); restart = 1'b0; k = 0;
      chk("wr_h_s0", 32'(h_s), 0);  chk("wr_v_s0", 32'(v_s), 0);
      chk("wr_fc_s4", 32'(fc_s), 4); chk("wr_fs_s", 32'(fs_s), 1);
      chk("wr_h_a0", 32'(h_a), 0);  chk("wr_fc_a0", 32'(fc_a), 0);
      adv_to(1); chk("wr1_fc_s", 32'(fc_s), 4); chk("wr1_h_s", 32'(h_s), 1);

      // asynchronous reset mid-line at default h=400
      adv_to(400);
      chk("pre_h_a", 32'(h_a), 400); chk("pre_de_a", 32'(de_a), 1);
      rst_p = 1'b1; #1;
      chk("ar_h_a", 32'(h_a), 0);   chk("ar_de_a", 32'(de_a), 0);
      chk("ar_red_a", 32'(red_a), 0); chk("ar_hs_a", 32'(hs_a), 1);
      chk("ar_h_s", 32'(h_s), 0);   chk("ar_v_s", 32'(v_s), 0);
      chk("ar_fc_s", 32'(fc_s), 0); chk("ar_hs_s", 32'(hs_s), 0);
      @(negedge clk);
      rst_p = 1'b0; k = 0;
      adv_to(1); chk("post_h_a_1", 32'(h_a), 1);
      adv_to(2); chk("post_h_a_2", 32'(h_a), 2);
      adv_to(3); chk("post_h_a_3", 32'(h_a), 3); chk("post_v_a", 32'(v_a), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
